// File: rtl/led_fade_driver_pkg.sv
// Shared constants and helpers for the LED fade driver and its per-channel slices.
package led_fade_driver_pkg;

    typedef enum logic [1:0] {
        RAMP_HOLD,
        RAMP_UP,
        RAMP_DOWN
    } ramp_dir_e;

    function automatic int dmax_of(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

    // Counter width for a modulus, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic pin_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED slice: ramped duty, period-aligned shadow duty and the PWM comparator.
module led_fade_channel
    import led_fade_driver_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                tick,
    input  logic                period_end,
    input  logic                req,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                on,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] DMAX_V = PWM_BITS'(dmax_of(PWM_BITS));

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_act;
    ramp_dir_e           dir;

    always_comb begin
        dir = RAMP_HOLD;
        if (req && (duty != DMAX_V)) begin
            dir = RAMP_UP;
        end else if (!req && (duty != '0)) begin
            dir = RAMP_DOWN;
        end
    end

    assign ramping = (dir != RAMP_HOLD);

    // Shadow load uses the pre-tick duty, so a step landing on a period end shows up one period later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty     <= '0;
            duty_act <= '0;
            on       <= 1'b0;
        end else if (!enable) begin
            duty     <= '0;
            duty_act <= '0;
            on       <= 1'b0;
        end else begin
            if (period_end) begin
                duty_act <= duty;
            end
            if (tick) begin
                case (dir)
                    RAMP_UP:   duty <= duty + PWM_BITS'(1);
                    RAMP_DOWN: duty <= duty - PWM_BITS'(1);
                    default:   duty <= duty;
                endcase
            end
            on <= (duty_act > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// PIO-driven LED fader: shared prescaler and PWM counter feeding one ramp/PWM slice per LED.
module led_fade_driver
    import led_fade_driver_pkg::*;
#(
    parameter int NUM_LEDS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 196078,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_req,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int                  DMAX     = dmax_of(PWM_BITS);
    localparam int                  PRE_W    = clog2_min1(PRESCALE);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(DMAX - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] req_q;
    logic [NUM_LEDS-1:0] on;
    logic [NUM_LEDS-1:0] ramping;
    logic                tick;
    logic                period_end;

    assign tick       = enable && (pre_cnt == PRE_LAST);
    assign period_end = enable && (pwm_cnt == PWM_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (!enable) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt <= period_end ? '0 : pwm_cnt + PWM_BITS'(1);
        end
    end

    // The request register keeps sampling while disabled so ramps resume from the live request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= '0;
            busy  <= 1'b0;
        end else begin
            req_q <= led_req;
            busy  <= enable && (|ramping);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .enable    (enable),
            .tick      (tick),
            .period_end(period_end),
            .req       (req_q[i]),
            .pwm_cnt   (pwm_cnt),
            .on        (on[i]),
            .ramping   (ramping[i])
        );

        assign led_out[i] = pin_level(on[i], ACTIVE_LOW != 0);
    end

endmodule
